if_fetch_stage: RTL and testbench
=================================

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port stall_in  input  1  high: decode stage cannot accept; IF/ID outputs hold.
REQ-005 SHALL have port redirect  input  1  taken branch/jump/trap from a later stage; flushes fetch.
REQ-006 SHALL have port redirect_pc  input  16 (lc3b_word)  new fetch address; bit 0 ignored.
REQ-007 SHALL have port imem_read  output  1  instruction memory read request.
REQ-008 SHALL have port imem_address  output  16  read address; stable while imem_read is high.
REQ-009 SHALL have port imem_resp  input  1  one-cycle pulse: imem_rdata valid.
REQ-010 SHALL have port imem_rdata  input  16  fetched instruction word.
REQ-011 SHALL have port ifid_valid  output  1  IF/ID holds a real instruction (low = bubble).
REQ-012 SHALL have port ifid_pc  output  16  address of the IF/ID instruction plus 2.
REQ-013 SHALL have port ifid_ir  output  16  IF/ID instruction word, consumed by the control decoder.

Function
REQ-014 SHALL implement states FETCH, HOLD, DRAIN.
REQ-015 FETCH: imem_read=1, imem_address=pc; HOLD: imem_read=0; DRAIN: imem_read=1, imem_address=drain_addr.
REQ-016 SHALL keep pc[0]=0 always; pc+2 wraps 16'hFFFE -> 16'h0000.
REQ-017 FETCH, imem_resp=1, stall_in=0, no redirect: ifid_ir<=imem_rdata, ifid_pc<=pc+2, ifid_valid<=1, pc<=pc+2, remain FETCH (one instruction per resp, zero added latency).
REQ-018 FETCH, imem_resp=1, stall_in=1, no redirect: skid buffer<=imem_rdata and pc+2, pc<=pc+2, go HOLD; IF/ID outputs unchanged.
REQ-019 HOLD, stall_in=0, no redirect: IF/ID<=skid buffer, ifid_valid<=1, go FETCH; stall_in=1: remain HOLD.
REQ-020 FETCH, imem_resp=0, stall_in=0: ifid_valid<=0 (bubble); stall_in=1: IF/ID hold.
REQ-021 redirect SHALL have priority over stall_in and imem_resp: pc<={redirect_pc[15:1],1'b0}, ifid_valid<=0, skid buffer invalidated.
REQ-022 redirect in FETCH with imem_resp=0: drain_addr<=pc, go DRAIN (outstanding read must complete, never aborted).
REQ-023 redirect in FETCH with imem_resp=1, or in HOLD: response discarded, go FETCH.
REQ-024 DRAIN, imem_resp=1: data discarded, go FETCH; redirect in DRAIN updates pc, remains DRAIN unless imem_resp=1.
REQ-025 SHALL never present a discarded word on ifid_ir with ifid_valid=1.
REQ-026 imem_address SHALL not change while imem_read is high and imem_resp has not arrived.

Reset
REQ-027 rst high SHALL immediately force state=FETCH, pc=RESET_PC, ifid_valid=0, ifid_pc=0, ifid_ir=0, skid buffer invalid, drain_addr=0.
REQ-028 Reset mid-read SHALL abandon the read; first post-reset read address = RESET_PC; a late imem_resp then SHALL be accepted as the RESET_PC response (memory is reset together).

Structure
REQ-029 lc3b_fetch_state enum (FETCH, HOLD, DRAIN) SHALL be added to lc3b_types; ports use lc3b_word.
REQ-030 FSM and datapath in one module; skid buffer MAY be sub-module if_skid_buf (16-bit data, 16-bit pc, valid).

Verification
REQ-031 Reset, imem_resp every cycle with rdata=16'h1234,16'h5678 -> addresses 0000,0002; ifid_ir 1234 then 5678, ifid_pc 0002 then 0004.
REQ-032 stall_in=1 for 3 cycles while resp returns 16'hABCD -> state HOLD, imem_read=0, IF/ID unchanged; stall drop -> ifid_ir=ABCD, valid=1 next cycle.
REQ-033 redirect to 16'h3001 during outstanding read at 0004 -> DRAIN, imem_address stays 0004; resp discarded (valid=0); next read address 3000.
REQ-034 redirect, stall_in, imem_resp same cycle -> ifid_valid=0, response dropped, next address = redirect target.
REQ-035 RESET_PC=16'hFFFE, resp -> next address 0000, ifid_pc=0000.
REQ-036 rst pulsed mid-DRAIN -> outputs zero immediately, state FETCH, address RESET_PC.

Source files
------------

// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word type and the instruction-fetch FSM state encoding.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN
    } lc3b_fetch_state;

endpackage

// File: rtl/if_skid_buf.sv
// if_skid_buf: one-entry skid buffer holding a fetched word and its pc+2 while decode stalls.
// Ports: i_load captures i_data/i_pc and sets o_valid; i_clear drops o_valid (load wins);
// o_valid/o_data/o_pc present the buffered entry. Async active-high reset clears everything.
module if_skid_buf
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_load,
    input  logic     i_clear,
    input  lc3b_word i_data,
    input  lc3b_word i_pc,
    output logic     o_valid,
    output lc3b_word o_data,
    output lc3b_word o_pc
);

    logic     r_valid;
    lc3b_word r_data;
    lc3b_word r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_pc    <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_pc    <= i_pc;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_pc    = r_pc;

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: LC-3b instruction fetch with IF/ID register, stall skid buffer and redirect drain.
// Ports: clk/rst (async active-high); stall_in holds IF/ID; redirect/redirect_pc restart fetch;
// imem_read/imem_address/imem_resp/imem_rdata talk to instruction memory;
// ifid_valid/ifid_pc/ifid_ir form the IF/ID register (ifid_pc is instruction address + 2).
module if_fetch_stage
    import lc3b_types::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000
)
(
    input  logic     clk,
    input  logic     rst,
    input  logic     stall_in,
    input  logic     redirect,
    input  lc3b_word redirect_pc,
    output logic     imem_read,
    output lc3b_word imem_address,
    input  logic     imem_resp,
    input  lc3b_word imem_rdata,
    output logic     ifid_valid,
    output lc3b_word ifid_pc,
    output lc3b_word ifid_ir
);

    localparam lc3b_word PC_INIT = {RESET_PC[15:1], 1'b0};

    lc3b_fetch_state r_state, w_state_nxt;
    lc3b_word        r_pc, w_pc_nxt;
    lc3b_word        r_drain_addr, w_drain_nxt;
    logic            r_ifid_valid, w_valid_nxt;
    lc3b_word        r_ifid_pc, w_ifid_pc_nxt;
    lc3b_word        r_ifid_ir, w_ifid_ir_nxt;
    logic            w_skid_ld, w_skid_clr, w_skid_valid;
    lc3b_word        w_skid_data, w_skid_pc;
    lc3b_word        w_pc_inc, w_redir_pc;

    assign w_pc_inc   = r_pc + 16'd2;
    assign w_redir_pc = {redirect_pc[15:1], 1'b0};

    if_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_ld),
        .i_clear (w_skid_clr),
        .i_data  (imem_rdata),
        .i_pc    (w_pc_inc),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data),
        .o_pc    (w_skid_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= FETCH;
            r_pc         <= PC_INIT;
            r_drain_addr <= '0;
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= '0;
            r_ifid_ir    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_drain_addr <= w_drain_nxt;
            r_ifid_valid <= w_valid_nxt;
            r_ifid_pc    <= w_ifid_pc_nxt;
            r_ifid_ir    <= w_ifid_ir_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_drain_nxt   = r_drain_addr;
        w_valid_nxt   = r_ifid_valid;
        w_ifid_pc_nxt = r_ifid_pc;
        w_ifid_ir_nxt = r_ifid_ir;
        w_skid_ld     = 1'b0;
        w_skid_clr    = 1'b0;
        if (redirect) begin
            w_pc_nxt    = w_redir_pc;
            w_valid_nxt = 1'b0;
            w_skid_clr  = 1'b1;
            // A read still in flight must be allowed to finish at its original address.
            w_state_nxt = (r_state == HOLD || imem_resp) ? FETCH : DRAIN;
            if (r_state == FETCH && !imem_resp)
                w_drain_nxt = r_pc;
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem_resp) begin
                        w_pc_nxt = w_pc_inc;
                        if (stall_in) begin
                            w_skid_ld   = 1'b1;
                            w_state_nxt = HOLD;
                        end else begin
                            w_valid_nxt   = 1'b1;
                            w_ifid_pc_nxt = w_pc_inc;
                            w_ifid_ir_nxt = imem_rdata;
                        end
                    end else if (!stall_in) begin
                        w_valid_nxt = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_in) begin
                        w_valid_nxt   = w_skid_valid;
                        w_ifid_pc_nxt = w_skid_pc;
                        w_ifid_ir_nxt = w_skid_data;
                        w_skid_clr    = 1'b1;
                        w_state_nxt   = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_resp)
                        w_state_nxt = FETCH;
                end
                default: w_state_nxt = FETCH;
            endcase
        end
    end

    assign imem_read    = (r_state != HOLD);
    assign imem_address = (r_state == DRAIN) ? r_drain_addr : r_pc;
    assign ifid_valid   = r_ifid_valid;
    assign ifid_pc      = r_ifid_pc;
    assign ifid_ir      = r_ifid_ir;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed self-checking bench for if_fetch_stage (default and FFFE reset PC).
module tb_if_fetch_stage;
    import lc3b_types::*;

    logic     clk = 1'b0;
    logic     rst;
    logic     stall_in, redirect, imem_resp;
    lc3b_word redirect_pc, imem_rdata;
    logic     imem_read, ifid_valid;
    lc3b_word imem_address, ifid_pc, ifid_ir;
    logic     b_imem_read, b_ifid_valid;
    lc3b_word b_imem_address, b_ifid_pc, b_ifid_ir;
    int       vectors = 0;
    int       miscompares = 0;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_read(imem_read), .imem_address(imem_address),
        .imem_resp(imem_resp), .imem_rdata(imem_rdata), .ifid_valid(ifid_valid),
        .ifid_pc(ifid_pc), .ifid_ir(ifid_ir)
    );

    if_fetch_stage #(.RESET_PC(16'hFFFE)) dut_b (
        .clk(clk), .rst(rst), .stall_in(stall_in), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_read(b_imem_read), .imem_address(b_imem_address),
        .imem_resp(imem_resp), .imem_rdata(imem_rdata), .ifid_valid(b_ifid_valid),
        .ifid_pc(b_ifid_pc), .ifid_ir(b_ifid_ir)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic rd, input lc3b_word rpc,
                         input logic rs, input lc3b_word data);
        stall_in = st; redirect = rd; redirect_pc = rpc; imem_resp = rs; imem_rdata = data;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 16'h0000, 0, 16'h0000);
        cyc();
        chk("rst_valid", {15'd0, ifid_valid}, 16'd0);
        chk("rst_pc", ifid_pc, 16'h0000);
        chk("rst_ir", ifid_ir, 16'h0000);
        chk("rst_read", {15'd0, imem_read}, 16'd1);
        chk("rst_addr", imem_address, 16'h0000);
        chk("b_rst_addr", b_imem_address, 16'hFFFE);
        rst = 1'b0;
        cyc();
        chk("idle_addr", imem_address, 16'h0000);
        chk("idle_valid", {15'd0, ifid_valid}, 16'd0);

        drive(0, 0, 16'h0000, 1, 16'h1234);
        cyc();
        chk("f1_ir", ifid_ir, 16'h1234);
        chk("f1_pc", ifid_pc, 16'h0002);
        chk("f1_valid", {15'd0, ifid_valid}, 16'd1);
        chk("f1_addr", imem_address, 16'h0002);
        chk("b_wrap_addr", b_imem_address, 16'h0000);
        chk("b_wrap_pc", b_ifid_pc, 16'h0000);
        chk("b_wrap_ir", b_ifid_ir, 16'h1234);

        drive(0, 0, 16'h0000, 1, 16'h5678);
        cyc();
        chk("f2_ir", ifid_ir, 16'h5678);
        chk("f2_pc", ifid_pc, 16'h0004);
        chk("f2_addr", imem_address, 16'h0004);

        drive(1, 0, 16'h0000, 1, 16'hABCD);
        cyc();
        chk("hold_read", {15'd0, imem_read}, 16'd0);
        chk("hold_ir", ifid_ir, 16'h5678);
        chk("hold_pc", ifid_pc, 16'h0004);
        chk("hold_valid", {15'd0, ifid_valid}, 16'd1);
        drive(1, 0, 16'h0000, 0, 16'h0000);
        cyc();
        cyc();
        chk("hold3_read", {15'd0, imem_read}, 16'd0);
        chk("hold3_ir", ifid_ir, 16'h5678);
        drive(0, 0, 16'h0000, 0, 16'h0000);
        cyc();
        chk("unskid_ir", ifid_ir, 16'hABCD);
        chk("unskid_pc", ifid_pc, 16'h0006);
        chk("unskid_valid", {15'd0, ifid_valid}, 16'd1);
        chk("unskid_addr", imem_address, 16'h0006);

        cyc();
        chk("bubble_valid", {15'd0, ifid_valid}, 16'd0);
        chk("bubble_addr", imem_address, 16'h0006);

        drive(0, 1, 16'h3001, 0, 16'h0000);
        cyc();
        chk("drain_read", {15'd0, imem_read}, 16'd1);
        chk("drain_addr", imem_address, 16'h0006);
        drive(0, 0, 16'h0000, 0, 16'h0000);
        cyc();
        chk("drain_addr2", imem_address, 16'h0006);
        drive(0, 0, 16'h0000, 1, 16'hDEAD);
        cyc();
        chk("drain_discard_valid", {15'd0, ifid_valid}, 16'd0);
        chk("drain_discard_ir", ifid_ir, 16'hABCD);
        chk("redir_addr", imem_address, 16'h3000);

        drive(1, 1, 16'h4000, 1, 16'hBEEF);
        cyc();
        chk("all3_valid", {15'd0, ifid_valid}, 16'd0);
        chk("all3_addr", imem_address, 16'h4000);
        chk("all3_read", {15'd0, imem_read}, 16'd1);
        chk("all3_ir", ifid_ir, 16'hABCD);
        drive(0, 0, 16'h0000, 1, 16'h1111);
        cyc();
        chk("post_ir", ifid_ir, 16'h1111);
        chk("post_pc", ifid_pc, 16'h4002);

        drive(1, 0, 16'h0000, 1, 16'h2222);
        cyc();
        chk("hold2_read", {15'd0, imem_read}, 16'd0);
        drive(1, 1, 16'h5000, 0, 16'h0000);
        cyc();
        chk("hredir_addr", imem_address, 16'h5000);
        chk("hredir_valid", {15'd0, ifid_valid}, 16'd0);
        drive(0, 0, 16'h0000, 0, 16'h0000);
        cyc();
        chk("skid_dropped_valid", {15'd0, ifid_valid}, 16'd0);
        chk("skid_dropped_ir", ifid_ir, 16'h1111);

        drive(0, 1, 16'h6000, 0, 16'h0000);
        cyc();
        chk("d2_addr", imem_address, 16'h5000);
        drive(0, 1, 16'h7000, 0, 16'h0000);
        cyc();
        chk("d2_redir_addr", imem_address, 16'h5000);
        drive(0, 0, 16'h0000, 0, 16'h0000);
        #2 rst = 1'b1;
        #1;
        chk("arst_addr", imem_address, 16'h0000);
        chk("arst_read", {15'd0, imem_read}, 16'd1);
        chk("arst_pc", ifid_pc, 16'h0000);
        chk("arst_ir", ifid_ir, 16'h0000);
        cyc();
        rst = 1'b0;
        drive(0, 0, 16'h0000, 1, 16'h3333);
        cyc();
        chk("late_ir", ifid_ir, 16'h3333);
        chk("late_pc", ifid_pc, 16'h0002);
        chk("late_valid", {15'd0, ifid_valid}, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
